vending_credit_ctrl: RTL and testbench

VENDING_CREDIT_CTRL -- requirements
Module: vending_credit_ctrl

---
 rtl/vending_credit_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_vending_credit_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vending_credit_ctrl.sv
// ---------------------------------------------------------------------------
// vending_credit_ctrl
// Coin-credit controller for a four-item vending machine.  Sums the coins
// inserted each cycle into a saturating credit register, resolves purchase
// requests by fixed priority and, on request, pays the remaining credit back
// as a greedy sequence of change coins.
//
// Ports
//   clk                      : single clock, rising-edge active
//   reset                    : asynchronous reset, active low
//   penny/nickel/dime/quarter: coin inserted this cycle (1/5/10/25)
//   apple/banana/carrot/date : purchase request for items A/B/C/D
//   coin_return              : pay out all remaining credit as change
//   credit   [CREDIT_W-1:0]  : current credit balance (registered)
//   vend     [3:0]           : one-hot dispense pulse, bit0 = A .. bit3 = D
//   deny                     : purchase refused, insufficient credit (pulse)
//   ovf                      : coin sum clipped at CREDIT_MAX (pulse)
//   change_out [3:0]         : one-hot change coin, bit0 = penny .. bit3 = quarter
//   busy                     : high while paying out change
// ---------------------------------------------------------------------------
module vending_credit_ctrl #(
   parameter int CREDIT_W   = 8,
   parameter int CREDIT_MAX = 2**CREDIT_W - 1,
   parameter int PRICE_A    = 75,
   parameter int PRICE_B    = 20,
   parameter int PRICE_C    = 30,
   parameter int PRICE_D    = 40
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                penny,
   input  logic                nickel,
   input  logic                dime,
   input  logic                quarter,
   input  logic                apple,
   input  logic                banana,
   input  logic                carrot,
   input  logic                date,
   input  logic                coin_return,
   output logic [CREDIT_W-1:0] credit,
   output logic [3:0]          vend,
   output logic                deny,
   output logic                ovf,
   output logic [3:0]          change_out,
   output logic                busy
);

   // Six extra bits leave room for the largest one-cycle coin total (41).
   localparam int SUM_W = CREDIT_W + 6;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_CHANGE = 1'b1
   } state_t;

   state_t              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [3:0]          r_vend;
   logic                r_deny;
   logic                r_ovf;
   logic [3:0]          r_change;
   logic                r_busy;

   state_t              w_state_n;
   logic [CREDIT_W-1:0] w_credit_n;
   logic [3:0]          w_vend_n;
   logic                w_deny_n;
   logic                w_ovf_n;
   logic [3:0]          w_change_n;

   logic [SUM_W-1:0]    w_sum;
   logic [CREDIT_W-1:0] w_post;
   logic                w_req;
   logic [3:0]          w_item_oh;
   logic [CREDIT_W-1:0] w_price;
   logic [CREDIT_W-1:0] w_coin_val;

   // Coin summation with saturation at CREDIT_MAX.
   always_comb begin
      w_sum = SUM_W'(r_credit)
            + (penny   ? SUM_W'(1)  : SUM_W'(0))
            + (nickel  ? SUM_W'(5)  : SUM_W'(0))
            + (dime    ? SUM_W'(10) : SUM_W'(0))
            + (quarter ? SUM_W'(25) : SUM_W'(0));
      if (w_sum > SUM_W'(CREDIT_MAX)) begin
         w_post  = CREDIT_W'(CREDIT_MAX);
         w_ovf_n = 1'b1;
      end else begin
         w_post  = w_sum[CREDIT_W-1:0];
         w_ovf_n = 1'b0;
      end
   end

   // Fixed-priority purchase selection: apple > banana > carrot > date.
   always_comb begin
      w_req     = 1'b1;
      w_item_oh = 4'b0000;
      w_price   = CREDIT_W'(0);
      if (apple) begin
         w_item_oh = 4'b0001;
         w_price   = CREDIT_W'(PRICE_A);
      end else if (banana) begin
         w_item_oh = 4'b0010;
         w_price   = CREDIT_W'(PRICE_B);
      end else if (carrot) begin
         w_item_oh = 4'b0100;
         w_price   = CREDIT_W'(PRICE_C);
      end else if (date) begin
         w_item_oh = 4'b1000;
         w_price   = CREDIT_W'(PRICE_D);
      end else begin
         w_req     = 1'b0;
      end
   end

   // Greedy change coin: largest denomination not exceeding the credit.
   always_comb begin
      if (r_credit >= CREDIT_W'(25)) begin
         w_coin_val = CREDIT_W'(25);
      end else if (r_credit >= CREDIT_W'(10)) begin
         w_coin_val = CREDIT_W'(10);
      end else if (r_credit >= CREDIT_W'(5)) begin
         w_coin_val = CREDIT_W'(5);
      end else if (r_credit >= CREDIT_W'(1)) begin
         w_coin_val = CREDIT_W'(1);
      end else begin
         w_coin_val = CREDIT_W'(0);
      end
   end

   // Next-state and next-output decode for the IDLE/CHANGE controller.
   always_comb begin
      w_state_n  = r_state;
      w_credit_n = r_credit;
      w_vend_n   = 4'b0000;
      w_deny_n   = 1'b0;
      w_change_n = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            w_credit_n = w_post;
            if (w_req) begin
               // Purchase wins over coin_return in the same cycle.
               if (w_post >= w_price) begin
                  w_credit_n = w_post - w_price;
                  w_vend_n   = w_item_oh;
               end else begin
                  w_deny_n   = 1'b1;
               end
            end else if (coin_return && (w_post != CREDIT_W'(0))) begin
               w_state_n = ST_CHANGE;
            end else begin
               w_state_n = ST_IDLE;
            end
         end
         ST_CHANGE: begin
            // w_coin_val never exceeds r_credit, so this cannot wrap.
            w_credit_n = r_credit - w_coin_val;
            case (w_coin_val)
               CREDIT_W'(25): w_change_n = 4'b1000;
               CREDIT_W'(10): w_change_n = 4'b0100;
               CREDIT_W'(5):  w_change_n = 4'b0010;
               CREDIT_W'(1):  w_change_n = 4'b0001;
               default:       w_change_n = 4'b0000;
            endcase
            if (w_credit_n == CREDIT_W'(0)) begin
               w_state_n = ST_IDLE;
            end else begin
               w_state_n = ST_CHANGE;
            end
         end
         default: begin
            w_state_n  = ST_IDLE;
            w_credit_n = CREDIT_W'(0);
         end
      endcase
   end

   // State and registered outputs; overflow is only reported while coins count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_credit <= CREDIT_W'(0);
         r_vend   <= 4'b0000;
         r_deny   <= 1'b0;
         r_ovf    <= 1'b0;
         r_change <= 4'b0000;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_credit <= w_credit_n;
         r_vend   <= w_vend_n;
         r_deny   <= w_deny_n;
         r_ovf    <= (r_state == ST_IDLE) ? w_ovf_n : 1'b0;
         r_change <= w_change_n;
         r_busy   <= (w_state_n == ST_CHANGE);
      end
   end

   assign credit     = r_credit;
   assign vend       = r_vend;
   assign deny       = r_deny;
   assign ovf        = r_ovf;
   assign change_out = r_change;
   assign busy       = r_busy;

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vending_credit_ctrl
// Directed, self-checking bench for vending_credit_ctrl with default
// parameters.  Inputs change 1 time unit after a rising edge; outputs are
// checked 1 time unit after the edge that produced them.
// ---------------------------------------------------------------------------
module tb_vending_credit_ctrl;

   logic       clk;
   logic       reset;
   logic       penny, nickel, dime, quarter;
   logic       apple, banana, carrot, date;
   logic       coin_return;
   logic [7:0] credit;
   logic [3:0] vend;
   logic       deny;
   logic       ovf;
   logic [3:0] change_out;
   logic       busy;

   int n_checks;
   int n_fail;

   vending_credit_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .penny       (penny),
      .nickel      (nickel),
      .dime        (dime),
      .quarter     (quarter),
      .apple       (apple),
      .banana      (banana),
      .carrot      (carrot),
      .date        (date),
      .coin_return (coin_return),
      .credit      (credit),
      .vend        (vend),
      .deny        (deny),
      .ovf         (ovf),
      .change_out  (change_out),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // coins: bit0 penny .. bit3 quarter; items: bit0 apple .. bit3 date
   task automatic drive(input logic [3:0] coins, input logic [3:0] items, input logic cr);
      penny       = coins[0];
      nickel      = coins[1];
      dime        = coins[2];
      quarter     = coins[3];
      apple       = items[0];
      banana      = items[1];
      carrot      = items[2];
      date        = items[3];
      coin_return = cr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [7:0] c, input logic [3:0] v,
                          input logic d, input logic o, input logic [3:0] ch, input logic b);
      chk({tag, ".credit"}, 32'(credit), 32'(c));
      chk({tag, ".vend"},   32'(vend),   32'(v));
      chk({tag, ".deny"},   32'(deny),   32'(d));
      chk({tag, ".ovf"},    32'(ovf),    32'(o));
      chk({tag, ".chg"},    32'(change_out), 32'(ch));
      chk({tag, ".busy"},   32'(busy),   32'(b));
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      chk_all("rst_async", 8'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      #2 reset = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive(4'b0000, 4'b0000, 1'b0);
      #1 reset = 1'b0;
      #1;
      chk_all("reset", 8'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      #1 reset = 1'b1;

      // Three quarters then apple
      drive(4'b1000, 4'b0000, 1'b0);
      tick(); chk("q1.credit", 32'(credit), 32'd25);
      tick(); chk("q2.credit", 32'(credit), 32'd50);
      tick(); chk("q3.credit", 32'(credit), 32'd75);
      drive(4'b0000, 4'b0001, 1'b0);
      tick(); chk_all("buyA", 8'd0, 4'b0001, 1'b0, 1'b0, 4'd0, 1'b0);
      drive(4'b0000, 4'b0000, 1'b0);
      tick(); chk_all("buyA_after", 8'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);

      // Insufficient credit for banana
      drive(4'b0100, 4'b0000, 1'b0);
      tick(); chk("dime.credit", 32'(credit), 32'd10);
      drive(4'b0000, 4'b0010, 1'b0);
      tick(); chk_all("denyB", 8'd10, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0);
      drive(4'b0000, 4'b0000, 1'b0);
      tick(); chk("denyB_after.deny", 32'(deny), 32'd0);

      // Saturation at 255
      do_reset();
      drive(4'b1000, 4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      chk_all("to250", 8'd250, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick(); chk_all("ovfQ", 8'd255, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);
      drive(4'b0100, 4'b0000, 1'b0);
      tick(); chk_all("ovfD", 8'd255, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);
      drive(4'b0000, 4'b0000, 1'b0);
      tick(); chk_all("ovf_after", 8'd255, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

      // Coins and carrot in the same cycle
      do_reset();
      drive(4'b1100, 4'b0100, 1'b0);
      tick(); chk_all("sameCyc", 8'd5, 4'b0100, 1'b0, 1'b0, 4'd0, 1'b0);

      // Priority: banana over date, post-coin 40 -> 20
      drive(4'b1100, 4'b1010, 1'b0);
      tick(); chk_all("prioBD", 8'd20, 4'b0010, 1'b0, 1'b0, 4'd0, 1'b0);
      // Apple wins over banana, apple unaffordable -> deny, banana discarded
      drive(4'b0000, 4'b0011, 1'b0);
      tick(); chk_all("prioAB", 8'd20, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0);
      // coin_return ignored when a purchase is requested
      drive(4'b0000, 4'b1000, 1'b1);
      tick(); chk_all("crIgn", 8'd20, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0);
      // Exact price leaves zero credit
      drive(4'b0000, 4'b0010, 1'b0);
      tick(); chk_all("exact", 8'd0, 4'b0010, 1'b0, 1'b0, 4'd0, 1'b0);
      // coin_return with zero credit does nothing
      drive(4'b0000, 4'b0000, 1'b1);
      tick(); chk_all("cr0", 8'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      drive(4'b0000, 4'b0000, 1'b0);
      tick(); chk("cr0_after.busy", 32'(busy), 32'd0);

      // Change payout of 41 with apple and quarter held during CHANGE
      drive(4'b1111, 4'b0000, 1'b0);
      tick(); chk("c41.credit", 32'(credit), 32'd41);
      drive(4'b0000, 4'b0000, 1'b1);
      tick(); chk_all("cr41", 8'd41, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
      drive(4'b1000, 4'b0001, 1'b1);
      tick(); chk_all("chg1", 8'd16, 4'd0, 1'b0, 1'b0, 4'b1000, 1'b1);
      tick(); chk_all("chg2", 8'd6,  4'd0, 1'b0, 1'b0, 4'b0100, 1'b1);
      tick(); chk_all("chg3", 8'd1,  4'd0, 1'b0, 1'b0, 4'b0010, 1'b1);
      drive(4'b0000, 4'b0000, 1'b0);
      tick(); chk_all("chg4", 8'd0,  4'd0, 1'b0, 1'b0, 4'b0001, 1'b0);
      tick(); chk_all("chg_done", 8'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

      // Reset in the middle of a payout
      drive(4'b1111, 4'b0000, 1'b0);
      tick(); chk("m41.credit", 32'(credit), 32'd41);
      drive(4'b0000, 4'b0000, 1'b1);
      tick();
      drive(4'b0000, 4'b0000, 1'b0);
      tick(); chk("mchg1.chg", 32'(change_out), 32'b1000);
      tick(); chk_all("mchg2", 8'd6, 4'd0, 1'b0, 1'b0, 4'b0100, 1'b1);
      do_reset();
      drive(4'b0001, 4'b0000, 1'b0);
      tick(); chk_all("postRst", 8'd1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      drive(4'b0000, 4'b0000, 1'b0);
      tick(); chk_all("postRst2", 8'd1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
